// File: rtl/scp_boot_loader.sv
// scp_boot_loader: receives a length-prefixed, XOR-checksummed program as a
// byte stream, writes it big-endian into instruction memory from word 0 and
// releases the processor reset once the checksum has been accepted.
module scp_boot_loader #(
  parameter int ADDR_WIDTH = 8,
  parameter int RST_HOLD   = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  cpu_reset,
  output logic                  boot_done,
  output logic                  error
);

  typedef enum logic [2:0] {
    ST_LEN_HI,
    ST_LEN_LO,
    ST_DATA,
    ST_CHECK,
    ST_HOLD,
    ST_RUN,
    ST_ERROR
  } state_t;

  state_t state, next_state;

  logic [15:0]         len;
  logic [1:0]          byte_cnt;
  logic [23:0]         word_sr;
  logic [ADDR_WIDTH:0] word_idx;
  logic [7:0]          xor_acc;
  logic [3:0]          hold_cnt;

  logic        accept;
  logic [31:0] len_new;
  logic [31:0] max_words;
  logic        last_word;

  assign accept    = in_valid && in_ready;
  assign len_new   = {16'd0, len[15:8], in_data};
  assign max_words = 32'd1 << ADDR_WIDTH;
  assign last_word = (32'(word_idx) + 32'd1) == {16'd0, len};

  // State register; reset returns to waiting for the length high byte.
  always_ff @(posedge clk) begin
    if (reset) state <= ST_LEN_HI;
    else       state <= next_state;
  end

  // Next-state logic driven by accepted bytes and the hold countdown.
  always_comb begin
    next_state = state;
    case (state)
      ST_LEN_HI: if (accept) next_state = ST_LEN_LO;
      ST_LEN_LO: begin
        if (accept) begin
          if (len_new > max_words)  next_state = ST_ERROR;
          else if (len_new == 32'd0) next_state = ST_CHECK;
          else                       next_state = ST_DATA;
        end
      end
      ST_DATA:  if (accept && byte_cnt == 2'd3 && last_word) next_state = ST_CHECK;
      ST_CHECK: begin
        if (accept) begin
          if (in_data == xor_acc) next_state = ST_HOLD;
          else                    next_state = ST_ERROR;
        end
      end
      ST_HOLD:  if (hold_cnt <= 4'd1) next_state = ST_RUN;
      ST_RUN:   next_state = ST_RUN;
      ST_ERROR: next_state = ST_ERROR;
      default:  next_state = ST_ERROR;
    endcase
  end

  // Status outputs decoded directly from the current state.
  always_comb begin
    in_ready  = (state == ST_LEN_HI) || (state == ST_LEN_LO) ||
                (state == ST_DATA)   || (state == ST_CHECK);
    cpu_reset = (state != ST_RUN);
    boot_done = (state == ST_RUN);
    error     = (state == ST_ERROR);
  end

  // Datapath: length capture, running XOR, word assembly, memory write and
  // the reset-hold countdown. The write strobe is a single-cycle pulse while
  // address and data stay put until the next word completes.
  always_ff @(posedge clk) begin
    if (reset) begin
      len        <= '0;
      byte_cnt   <= '0;
      word_sr    <= '0;
      word_idx   <= '0;
      xor_acc    <= '0;
      hold_cnt   <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
    end else begin
      imem_we <= 1'b0;
      case (state)
        ST_LEN_HI: begin
          if (accept) begin
            len[15:8] <= in_data;
            xor_acc   <= xor_acc ^ in_data;
          end
        end
        ST_LEN_LO: begin
          if (accept) begin
            len[7:0] <= in_data;
            xor_acc  <= xor_acc ^ in_data;
          end
        end
        ST_DATA: begin
          if (accept) begin
            xor_acc  <= xor_acc ^ in_data;
            byte_cnt <= byte_cnt + 2'd1;
            word_sr  <= {word_sr[15:0], in_data};
            if (byte_cnt == 2'd3) begin
              imem_we    <= 1'b1;
              imem_addr  <= word_idx[ADDR_WIDTH-1:0];
              imem_wdata <= {word_sr, in_data};
              word_idx   <= word_idx + 1'b1;
            end
          end
        end
        ST_CHECK: begin
          if (accept && in_data == xor_acc) hold_cnt <= 4'(RST_HOLD);
        end
        ST_HOLD: hold_cnt <= hold_cnt - 4'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_scp_boot_loader.sv
// Randomised scoreboard bench for scp_boot_loader: a stream-level reference
// model predicts memory writes and the final outcome of each byte stream.
module tb_scp_boot_loader;

  localparam int AW = 8;
  localparam int RH = 2;

  typedef logic [7:0] bq_t[$];
  typedef logic [31:0] wq_t[$];
  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  logic          clk = 1'b0;
  logic          reset;
  logic [7:0]    in_data;
  logic          in_valid;
  logic          in_ready;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          cpu_reset;
  logic          boot_done;
  logic          error;

  wr_t expQ[$];
  int  checks = 0;
  int  fails  = 0;

  scp_boot_loader #(.ADDR_WIDTH(AW), .RST_HOLD(RH)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .cpu_reset(cpu_reset), .boot_done(boot_done),
    .error(error)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe is popped against the scoreboard.
  logic prevWe = 1'b0;
  always @(negedge clk) begin : monitor
    wr_t e;
    if (imem_we === 1'b1) begin
      checkOutput("we_single_cycle", {31'd0, prevWe}, 32'd0);
      if (expQ.size() == 0) begin
        checks++;
        fails++;
        $display("[TB] FAIL unexpected_write: got addr 0x%02h data 0x%08h expected no write", imem_addr, imem_wdata);
      end else begin
        e = expQ.pop_front();
        checkOutput("write_addr", {24'd0, imem_addr}, {24'd0, e.addr});
        checkOutput("write_data", imem_wdata, e.data);
      end
    end
    prevWe = imem_we;
  end

  // Reference model: parses a (possibly truncated) stream, queues the words
  // it fully delivers and reports 0=incomplete, 1=boots, 2=error, plus the
  // index of the last byte the loader will accept.
  task automatic modelStream(input bq_t s, output int outcome, output int lastIdx);
    int n;
    int chk;
    logic [7:0] x;
    wr_t w;
    outcome = 0;
    lastIdx = s.size() - 1;
    if (s.size() < 2) return;
    n = int'(s[0]) * 256 + int'(s[1]);
    if (n > (1 << AW)) begin
      outcome = 2;
      lastIdx = 1;
      return;
    end
    for (int k = 0; k < n; k++) begin
      if (2 + 4*k + 3 < s.size()) begin
        w.addr = k[AW-1:0];
        w.data = {s[2+4*k], s[3+4*k], s[4+4*k], s[5+4*k]};
        expQ.push_back(w);
      end
    end
    chk = 2 + 4*n;
    if (chk < s.size()) begin
      x = 8'h00;
      for (int i = 0; i < chk; i++) x = x ^ s[i];
      outcome = (s[chk] == x) ? 1 : 2;
      lastIdx = chk;
    end
  endtask

  function automatic bq_t buildStream(input wq_t w, input bit bad);
    bq_t s;
    int n;
    logic [7:0] x;
    n = w.size();
    s.push_back(n[15:8]);
    s.push_back(n[7:0]);
    foreach (w[i]) begin
      s.push_back(w[i][31:24]);
      s.push_back(w[i][23:16]);
      s.push_back(w[i][15:8]);
      s.push_back(w[i][7:0]);
    end
    x = 8'h00;
    foreach (s[i]) x = x ^ s[i];
    if (bad) x = x ^ 8'($urandom_range(255, 1));
    s.push_back(x);
    return s;
  endfunction

  task automatic sendByte(input logic [7:0] b, input int gapMax);
    int gap;
    gap = (gapMax > 0) ? int'($urandom_range(gapMax, 0)) : 0;
    repeat (gap) begin
      in_valid = 1'b0;
      in_data  = 8'($urandom);
      @(negedge clk);
    end
    in_valid = 1'b1;
    in_data  = b;
    checkOutput("in_ready_before_byte", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic applyReset();
    @(negedge clk);
    reset    = 1'b1;
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("rst_in_ready",   {31'd0, in_ready},  32'd1);
    checkOutput("rst_cpu_reset",  {31'd0, cpu_reset}, 32'd1);
    checkOutput("rst_imem_we",    {31'd0, imem_we},   32'd0);
    checkOutput("rst_boot_done",  {31'd0, boot_done}, 32'd0);
    checkOutput("rst_error",      {31'd0, error},     32'd0);
    checkOutput("rst_imem_addr",  {24'd0, imem_addr}, 32'd0);
    checkOutput("rst_imem_wdata", imem_wdata,         32'd0);
    expQ.delete();
    reset = 1'b0;
  endtask

  // Sends the part of the stream the loader will accept, then checks the
  // release or error behaviour the model predicts and that all writes came.
  task automatic applyStimulus(input bq_t s, input int gapMax);
    int outcome;
    int lastIdx;
    modelStream(s, outcome, lastIdx);
    for (int i = 0; i <= lastIdx; i++) sendByte(s[i], gapMax);
    if (outcome == 1) begin
      checkOutput("hold_in_ready", {31'd0, in_ready}, 32'd0);
      for (int j = 0; j < RH; j++) begin
        checkOutput("hold_cpu_reset", {31'd0, cpu_reset}, 32'd1);
        checkOutput("hold_boot_done", {31'd0, boot_done}, 32'd0);
        @(negedge clk);
      end
      checkOutput("run_cpu_reset", {31'd0, cpu_reset}, 32'd0);
      checkOutput("run_boot_done", {31'd0, boot_done}, 32'd1);
      checkOutput("run_error",     {31'd0, error},     32'd0);
    end else if (outcome == 2) begin
      checkOutput("err_error",     {31'd0, error},     32'd1);
      checkOutput("err_in_ready",  {31'd0, in_ready},  32'd0);
      checkOutput("err_cpu_reset", {31'd0, cpu_reset}, 32'd1);
      checkOutput("err_boot_done", {31'd0, boot_done}, 32'd0);
      in_valid = 1'b1;
      in_data  = 8'hFF;
      repeat (3) @(negedge clk);
      in_valid = 1'b0;
      checkOutput("err_sticky", {31'd0, error}, 32'd1);
    end
    @(negedge clk);
    checkOutput("writes_drained", expQ.size(), 32'd0);
  endtask

  bq_t goodS;
  bq_t tmpS;
  wq_t words;

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    goodS = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h20, 8'h09, 8'h00, 8'h0A, 8'h0C};

    applyReset();

    // Good load at full rate, then input during RUN must be ignored.
    applyStimulus(goodS, 0);
    checkOutput("good_last_addr", {24'd0, imem_addr}, 32'd1);
    checkOutput("good_last_data", imem_wdata, 32'h2009000A);
    in_valid = 1'b1;
    in_data  = 8'hFF;
    repeat (6) @(negedge clk);
    in_valid = 1'b0;
    checkOutput("run_ignore_boot_done", {31'd0, boot_done}, 32'd1);
    checkOutput("run_ignore_in_ready",  {31'd0, in_ready},  32'd0);
    checkOutput("run_ignore_cpu_reset", {31'd0, cpu_reset}, 32'd0);

    // Bad checksum.
    applyReset();
    tmpS = goodS;
    tmpS[10] = 8'h0D;
    applyStimulus(tmpS, 0);

    // Empty program and oversize length.
    applyReset();
    applyStimulus('{8'h00, 8'h00, 8'h00}, 0);
    applyReset();
    applyStimulus('{8'h01, 8'h01}, 0);

    // Good load with random valid gaps.
    applyReset();
    applyStimulus(goodS, 3);

    // Reset after the fifth byte, then the full stream again.
    applyReset();
    tmpS = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00};
    applyStimulus(tmpS, 0);
    applyReset();
    applyStimulus(goodS, 0);

    // Random programs, some with corrupted checksums.
    for (int r = 0; r < 6; r++) begin
      applyReset();
      words.delete();
      for (int k = 0; k < int'($urandom_range(8, 0)); k++) words.push_back($urandom);
      applyStimulus(buildStream(words, ($urandom_range(3, 0) == 0)), 3);
    end

    // Full-capacity program: the last address is 2^AW-1.
    applyReset();
    words.delete();
    for (int k = 0; k < (1 << AW); k++) words.push_back($urandom);
    applyStimulus(buildStream(words, 1'b0), 0);
    checkOutput("full_last_addr", {24'd0, imem_addr}, 32'd255);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  // Guard against a stuck run.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/scp_boot_loader.md
# scp_boot_loader

Byte-stream boot loader upstream of `MIPS_SCP`. It holds the processor in reset and receives a length-prefixed, checksummed program over a valid/ready byte interface. It assembles the bytes into big-endian 32-bit words and writes them into the instruction memory write port from word address 0. After a good checksum it releases the processor reset. This replaces `$readmemh` preloading, so the same program image boots in simulation and on hardware.

## Interface
- `ADDR_WIDTH`, 8: instruction-memory word-address width; capacity is 2^ADDR_WIDTH words.
- `RST_HOLD`, 2: cycles `cpu_reset` stays high after the checksum is accepted (range 1..15).

- `clk` input 1: single clock, shared with `MIPS_SCP`.
- `reset` input 1: synchronous, active-high.
- `in_data` input 8: stream byte.
- `in_valid` input 1: `in_data` is valid.
- `in_ready` output 1: loader accepts a byte this cycle.
- `imem_we` output 1: one-cycle instruction-memory write strobe.
- `imem_addr` output ADDR_WIDTH: word address of the write.
- `imem_wdata` output 32: word to write.
- `cpu_reset` output 1: drives `MIPS_SCP.reset`.
- `boot_done` output 1: program loaded; CPU running.
- `error` output 1: load failed; sticky until `reset`.

## Operation
- **Stream format:**
  - LEN_HI byte, LEN_LO byte: 16-bit word count N.
  - 4·N data bytes; the first byte of each word goes to [31:24].
  - CHK byte: XOR of all preceding stream bytes, length bytes included.
- **Byte acceptance:** a byte is accepted on a rising edge where `in_valid && in_ready`. `in_data` is ignored otherwise.
- **States:** LEN_HI → LEN_LO → DATA → CHECK → HOLD → RUN. ERROR is terminal.
  - LEN_HI: accept byte into N[15:8]; go to LEN_LO.
  - LEN_LO: accept byte into N[7:0].
    - N > 2^ADDR_WIDTH: go to ERROR.
    - N = 0: go to CHECK.
    - Otherwise: go to DATA.
  - DATA: a 2-bit byte counter shifts bytes into the word register. On the 4th byte, issue the write and increment the word index. After word N-1 is written, go to CHECK.
  - CHECK: accept one byte.
    - Byte equals running XOR: go to HOLD, load the hold counter with RST_HOLD.
    - Otherwise: go to ERROR.
  - HOLD: decrement the counter; at 1, go to RUN.
  - RUN: `cpu_reset`=0, `boot_done`=1. All input is ignored.
  - ERROR: `error`=1, `cpu_reset`=1. All input is ignored.
- **`in_ready`:** 1 in LEN_HI, LEN_LO, DATA and CHECK; 0 in HOLD, RUN and ERROR.
- **Running XOR:** cleared in LEN_HI on reset; updated on every accepted byte before CHECK.
- **Word index:** ADDR_WIDTH+1 bits wide so that N = 2^ADDR_WIDTH is legal. The last address is 2^ADDR_WIDTH−1; there is no wrap.

## Timing
- **Reset values:** state LEN_HI, `in_ready`=1, `imem_we`=0, `imem_addr`=0, `imem_wdata`=0, `cpu_reset`=1, `boot_done`=0, `error`=0. Counters and the XOR register are 0.
- **Write latency:** the edge that accepts the 4th byte of word k registers `imem_we`=1, `imem_addr`=k and the full word.
  - The strobe is visible for exactly the next cycle.
  - `imem_addr` and `imem_wdata` hold until the next write.
- **Throughput:** one byte per cycle at full rate. Back-to-back words give `imem_we` high for 1 cycle in every 4.
- **Stalls:** `in_valid` gaps stall without penalty; partial-word state is retained.
- **Reset release:** the edge accepting a good CHK byte starts HOLD. `cpu_reset` falls on the RST_HOLD-th edge after it. `boot_done` rises on the same edge.
  - The last `imem_we` therefore precedes the CPU's first fetch by ≥1 cycle.
- **Error timing:** `error` rises on the edge that accepts the offending byte (LEN_LO overflow or CHK mismatch). `in_ready` falls on that same edge.
- **Reset mid-operation:** `reset` high at any edge, in any state, returns all outputs to reset values on that edge.
  - The partial word, N and the XOR register are discarded.
  - Words already written are not erased.
- **Simultaneous events:** `reset` has priority over `in_valid`.

## Test plan
- **Reset:** assert `reset` 2 cycles → `cpu_reset`=1, `in_ready`=1, `imem_we`=0, `boot_done`=0, `error`=0.
- **Good load:** stream 00 02 20 08 00 05 20 09 00 0A 0C at full rate → writes addr0=0x20080005 and addr1=0x2009000A, one cycle each. `cpu_reset` falls 2 edges after 0C is accepted; `boot_done`=1; the CPU fetches 0x20080005 at PC 0.
- **Bad checksum:** same stream ending in 0D → both writes occur, `error`=1, `cpu_reset` stays 1, `in_ready`=0, `boot_done`=0.
- **Empty and overflow programs:**
  - Stream 00 00 00 → no `imem_we`, `boot_done`=1.
  - Stream 01 01 → `error`=1 after the second byte, no writes.
- **Stalls and ignored input:** repeat the good load with random 0–3 cycle `in_valid` gaps → identical writes and release. During RUN, drive `in_valid`=1 with data FF → no state change and no writes.
- **Reset mid-load:** pulse `reset` after the 5th byte of the good stream, then resend the full stream → final memory and release are identical to the good load; no stale partial word is written.
